// File: rtl/rvc_fetch_aligner.sv
// ---------------------------------------------------------------------------
// rvc_fetch_aligner
//
// Turns halfword-aligned PC requests from the fetch stage into complete raw
// instructions (16-bit RVC or 32-bit). It is the instruction cache's
// upstream requester. A 32-bit instruction that starts in the upper half of
// a word is assembled from two cache words. Compressed instructions are
// returned zero-extended with if_rvc set.
//
// Optional feature (macro WORD_REUSE_EN): a request whose word address
// matches the last fetched word is decoded straight from the word buffer,
// which skips the first cache access.
//
// Ports:
//   clk           clock
//   proc_reset    synchronous active-high reset
//   if_req        core request; held with if_pc stable until if_valid
//   if_pc         instruction PC (ADDR_W+2 bits, bit0 ignored)
//   if_flush      redirect: abort the current request
//   if_valid      one-cycle pulse, if_inst/if_rvc valid
//   if_inst       raw instruction, RVC as {16'b0, half}
//   if_rvc        instruction is compressed
//   if_busy       aligner is not idle
//   ICACHE_ren    cache read request
//   ICACHE_addr   cache word address
//   ICACHE_stall  cache busy; data valid when ren=1 and stall=0
//   ICACHE_rdata  cache word
//
// state | meaning
// IDLE  | waiting for a request
// F0    | reading the word that holds the PC
// F1    | reading the next word for the upper half of a spilled instruction
// RESP  | if_valid pulse with the assembled instruction
// ---------------------------------------------------------------------------
module rvc_fetch_aligner #(
    parameter int          ADDR_W    = 30,
    parameter logic [31:0] IDLE_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              if_req,
    input  logic [ADDR_W+1:0] if_pc,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    output logic              if_rvc,
    output logic              if_busy,
    output logic              ICACHE_ren,
    output logic [ADDR_W-1:0] ICACHE_addr,
    input  logic              ICACHE_stall,
    input  logic [31:0]       ICACHE_rdata
);

    typedef enum logic [1:0] {IDLE, F0, F1, RESP} state_t;

    localparam logic [ADDR_W-1:0] WORD_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W+1:0] pc_q;
    logic [15:0]       hi_q;
    logic              flush_pend;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [31:0]       buf_data;

    logic              take_req;
    logic              reuse_hit;
    logic              cache_done;
    logic              abort;
    logic [31:0]       dec_word;
    logic              dec_half;
    logic [15:0]       dec_lo;
    logic              dec_rvc;
    logic              dec_spill;
    logic [31:0]       dec_inst;
    logic              unused_ok;

    assign ICACHE_ren = (state == F0) || (state == F1);
    assign if_valid   = (state == RESP);
    assign if_busy    = (state != IDLE);

    // Only pc_q[1] is needed after the request is taken; the word address
    // lives in ICACHE_addr. Without the reuse feature the buffer is never read.
    assign unused_ok = ^{if_pc[0], pc_q[ADDR_W+1:2], pc_q[0],
                         buf_valid, buf_tag, buf_data};

    always_comb begin
        state_nxt  = state;
        take_req   = 1'b0;
        reuse_hit  = 1'b0;
        cache_done = ICACHE_ren && !ICACHE_stall;
        abort      = flush_pend || if_flush;
        dec_word   = ICACHE_rdata;
        dec_half   = pc_q[1];
`ifdef WORD_REUSE_EN
        // In IDLE the decoder looks at the buffered word for a possible hit.
        if (state == IDLE) begin
            dec_word = buf_data;
            dec_half = if_pc[1];
        end
`endif
        dec_lo    = dec_half ? dec_word[31:16] : dec_word[15:0];
        dec_rvc   = (dec_lo[1:0] != 2'b11);
        dec_spill = dec_half && !dec_rvc;
        dec_inst  = dec_rvc ? {16'h0000, dec_lo} : dec_word;

        case (state)
            IDLE: begin
                if (if_req && !if_flush) begin
                    take_req = 1'b1;
`ifdef WORD_REUSE_EN
                    reuse_hit = buf_valid && (buf_tag == if_pc[ADDR_W+1:2]);
`endif
                    if (reuse_hit)
                        state_nxt = dec_spill ? F1 : RESP;
                    else
                        state_nxt = F0;
                end
            end
            F0: begin
                if (cache_done) begin
                    if (abort)
                        state_nxt = IDLE;
                    else
                        state_nxt = dec_spill ? F1 : RESP;
                end
            end
            F1: begin
                if (cache_done)
                    state_nxt = abort ? IDLE : RESP;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            pc_q        <= '0;
            hi_q        <= '0;
            flush_pend  <= 1'b0;
            ICACHE_addr <= '0;
            if_inst     <= IDLE_INST;
            if_rvc      <= 1'b0;
            buf_valid   <= 1'b0;
            buf_tag     <= '0;
            buf_data    <= '0;
        end else begin
            if (take_req) begin
                pc_q <= if_pc;
                if (reuse_hit && dec_spill) begin
                    hi_q        <= dec_word[31:16];
                    ICACHE_addr <= if_pc[ADDR_W+1:2] + WORD_ONE;
                end else begin
                    ICACHE_addr <= if_pc[ADDR_W+1:2];
                end
                if (reuse_hit && !dec_spill) begin
                    if_inst <= dec_inst;
                    if_rvc  <= dec_rvc;
                end
            end

            // Every completed cache read refreshes the buffer, even when the
            // request was flushed: the word itself is still correct.
            if (cache_done) begin
                buf_valid <= 1'b1;
                buf_tag   <= ICACHE_addr;
                buf_data  <= ICACHE_rdata;
            end

            if (state == F0 && cache_done && !abort) begin
                if (dec_spill) begin
                    hi_q        <= ICACHE_rdata[31:16];
                    ICACHE_addr <= ICACHE_addr + WORD_ONE;
                end else begin
                    if_inst <= dec_inst;
                    if_rvc  <= dec_rvc;
                end
            end

            if (state == F1 && cache_done && !abort) begin
                if_inst <= {ICACHE_rdata[15:0], hi_q};
                if_rvc  <= 1'b0;
            end

            // A flush during a miss cannot cancel the cache access, so it is
            // remembered until the outstanding read returns.
            if (cache_done)
                flush_pend <= 1'b0;
            else if (ICACHE_ren && if_flush)
                flush_pend <= 1'b1;

            if (if_flush) begin
                if_inst <= IDLE_INST;
                if_rvc  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
module tb_rvc_fetch_aligner;

    localparam int ADDR_W = 30;
`ifdef WORD_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              proc_reset;
    logic              if_req;
    logic [31:0]       if_pc;
    logic              if_flush;
    logic              if_valid;
    logic [31:0]       if_inst;
    logic              if_rvc;
    logic              if_busy;
    logic              ICACHE_ren;
    logic [ADDR_W-1:0] ICACHE_addr;
    logic              ICACHE_stall;
    logic [31:0]       ICACHE_rdata;

    int tests = 0;
    int fails = 0;
    int stall_left = 0;
    int accesses = 0;

    logic [31:0] mem [logic [29:0]];
    logic [31:0] exp_inst_q [$];
    logic        exp_rvc_q  [$];
    logic [29:0] exp_addr_q [$];
    logic        tb_tag_valid = 1'b0;
    logic [29:0] tb_tag = '0;

    rvc_fetch_aligner #(.ADDR_W(ADDR_W), .IDLE_INST(32'h00000013)) dut (
        .clk         (clk),
        .proc_reset  (proc_reset),
        .if_req      (if_req),
        .if_pc       (if_pc),
        .if_flush    (if_flush),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_rvc      (if_rvc),
        .if_busy     (if_busy),
        .ICACHE_ren  (ICACHE_ren),
        .ICACHE_addr (ICACHE_addr),
        .ICACHE_stall(ICACHE_stall),
        .ICACHE_rdata(ICACHE_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [29:0] a);
        if (mem.exists(a))
            return mem[a];
        return 32'hDEADBEEF;
    endfunction

    // Cache model: data and stall settle mid-cycle; completed reads are
    // checked against the expected address sequence.
    always @(negedge clk) begin
        ICACHE_rdata = rd(ICACHE_addr);
        if (ICACHE_ren === 1'b1 && stall_left > 0) begin
            ICACHE_stall = 1'b1;
            stall_left--;
        end else begin
            ICACHE_stall = 1'b0;
            if (ICACHE_ren === 1'b1) begin
                logic [29:0] ea;
                accesses++;
                tests++;
                if (exp_addr_q.size() == 0) begin
                    fails++;
                    $display("FAIL cache_addr: unexpected access to %h", ICACHE_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (ICACHE_addr !== ea) begin
                        fails++;
                        $display("FAIL cache_addr: got %h expected %h", ICACHE_addr, ea);
                    end
                end
            end
        end
    end

    // Output monitor: every if_valid pulse consumes one expected response.
    always @(posedge clk) begin
        #1;
        if (if_valid === 1'b1) begin
            logic [31:0] ei;
            logic        er;
            tests++;
            if (exp_inst_q.size() == 0) begin
                fails++;
                $display("FAIL resp: unexpected if_valid inst=%h", if_inst);
            end else begin
                ei = exp_inst_q.pop_front();
                er = exp_rvc_q.pop_front();
                if (if_inst !== ei || if_rvc !== er) begin
                    fails++;
                    $display("FAIL resp: got inst=%h rvc=%b expected inst=%h rvc=%b",
                             if_inst, if_rvc, ei, er);
                end
            end
        end
    end

    // Issues one request, pushing the reference result/addresses computed
    // from the memory contents, and measures request-to-valid latency.
    task automatic fetch(input logic [31:0] pc, input int stall,
                         output int lat, output int exp_lat);
        logic [29:0] w;
        logic [31:0] lo_w;
        logic [31:0] hi_w;
        logic [15:0] lo;
        logic [31:0] ei;
        logic        er;
        bit          hit;
        bit          spill;
        int          st;
        w     = pc[31:2];
        hit   = REUSE && tb_tag_valid && (tb_tag == w);
        lo_w  = rd(w);
        lo    = pc[1] ? lo_w[31:16] : lo_w[15:0];
        er    = (lo[1:0] != 2'b11);
        spill = pc[1] && !er;
        if (er)
            ei = {16'h0000, lo};
        else if (!pc[1])
            ei = lo_w;
        else begin
            hi_w = rd(w + 30'd1);
            ei   = {hi_w[15:0], lo};
        end
        if (!hit)
            exp_addr_q.push_back(w);
        if (spill)
            exp_addr_q.push_back(w + 30'd1);
        st      = (hit && !spill) ? 0 : stall;
        exp_lat = (hit ? 1 : 2) + (spill ? 1 : 0) + st;
        tb_tag_valid = 1'b1;
        tb_tag       = spill ? w + 30'd1 : w;
        exp_inst_q.push_back(ei);
        exp_rvc_q.push_back(er);

        @(posedge clk);
        #2;
        stall_left = st;
        if_pc      = pc;
        if_req     = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (if_valid !== 1'b1 && lat < 50);
        #1;
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        proc_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        tests++; if (if_inst !== 32'h00000013) begin fails++; $display("FAIL reset_inst: got %h expected 00000013", if_inst); end
        tests++; if (if_rvc !== 1'b0) begin fails++; $display("FAIL reset_rvc: got %b expected 0", if_rvc); end
        tests++; if (if_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", if_busy); end
        tests++; if (ICACHE_ren !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b expected 0", ICACHE_ren); end
        tests++; if (ICACHE_addr !== 30'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", ICACHE_addr); end
        #1;
        proc_reset   = 1'b0;
        tb_tag_valid = 1'b0;
    endtask

    task automatic test_aligned32();
        int lat, el;
        fetch(32'h00000100, 0, lat, el);
        tests++; if (lat !== 2 || el !== 2) begin fails++; $display("FAIL aligned32_lat: got %0d expected 2", lat); end
        tests++; if (if_inst !== 32'h00A00093 || if_rvc !== 1'b0) begin fails++; $display("FAIL aligned32_inst: got %h/%b expected 00a00093/0", if_inst, if_rvc); end
        tests++; if (ICACHE_ren !== 1'b0 || ICACHE_addr !== 30'h40) begin fails++; $display("FAIL aligned32_bus: got ren=%b addr=%h expected ren=0 addr=40", ICACHE_ren, ICACHE_addr); end
    endtask

    task automatic test_rvc();
        int lat, el, a0;
        a0 = accesses;
        fetch(32'h00000104, 0, lat, el);
        tests++; if (if_inst !== 32'h00004505 || if_rvc !== 1'b1) begin fails++; $display("FAIL rvc_low_inst: got %h/%b expected 00004505/1", if_inst, if_rvc); end
        tests++; if (accesses - a0 !== 1) begin fails++; $display("FAIL rvc_low_access: got %0d expected 1", accesses - a0); end
        a0 = accesses;
        fetch(32'h00000106, 0, lat, el);
        tests++; if (if_inst !== 32'h00001234 || if_rvc !== 1'b1) begin fails++; $display("FAIL rvc_high_inst: got %h/%b expected 00001234/1", if_inst, if_rvc); end
        tests++; if (accesses - a0 !== (REUSE ? 0 : 1)) begin fails++; $display("FAIL rvc_high_access: got %0d expected %0d", accesses - a0, REUSE ? 0 : 1); end
        tests++; if (lat !== el || lat !== (REUSE ? 1 : 2)) begin fails++; $display("FAIL rvc_high_lat: got %0d expected %0d", lat, REUSE ? 1 : 2); end
    endtask

    task automatic test_spill();
        int lat, el, a0;
        a0 = accesses;
        fetch(32'h0000010A, 0, lat, el);
        tests++; if (if_inst !== 32'h00A00093 || if_rvc !== 1'b0) begin fails++; $display("FAIL spill_inst: got %h/%b expected 00a00093/0", if_inst, if_rvc); end
        tests++; if (accesses - a0 !== 2) begin fails++; $display("FAIL spill_access: got %0d expected 2", accesses - a0); end
        tests++; if (lat !== el || lat !== 3) begin fails++; $display("FAIL spill_lat: got %0d expected 3", lat); end
        fetch(32'hFFFFFFFE, 2, lat, el);
        tests++; if (if_inst !== 32'h00FF1073 || if_rvc !== 1'b0) begin fails++; $display("FAIL spill_wrap_inst: got %h/%b expected 00ff1073/0", if_inst, if_rvc); end
        tests++; if (lat !== el || lat !== 5) begin fails++; $display("FAIL spill_wrap_lat: got %0d expected 5", lat); end
        tests++; if (ICACHE_addr !== 30'h0) begin fails++; $display("FAIL spill_wrap_addr: got %h expected 0", ICACHE_addr); end
    endtask

    task automatic test_stall_hit();
        int lat, el;
        fetch(32'h00000100, 3, lat, el);
        tests++; if (lat !== el || lat !== 5) begin fails++; $display("FAIL stall_lat: got %0d expected 5", lat); end
    endtask

    task automatic test_flush_miss();
        bit ren_ok, seen_valid;
        int a0;
        a0 = accesses;
        ren_ok = 1'b1;
        seen_valid = 1'b0;
        exp_addr_q.push_back(30'h80);
        tb_tag_valid = 1'b1;
        tb_tag = 30'h80;
        @(posedge clk);
        #2;
        stall_left = 10;
        if_pc  = 32'h00000200;
        if_req = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(posedge clk);
            #1;
            if (if_valid === 1'b1) seen_valid = 1'b1;
            if (i <= 10 && (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h80)) ren_ok = 1'b0;
            #1;
            if (i == 3) begin if_flush = 1'b1; if_req = 1'b0; end
            if (i == 4) if_flush = 1'b0;
        end
        tests++; if (ren_ok !== 1'b1) begin fails++; $display("FAIL flush_ren_hold: got %b expected 1", ren_ok); end
        tests++; if (seen_valid !== 1'b0) begin fails++; $display("FAIL flush_no_valid: got %b expected 0", seen_valid); end
        tests++; if (if_inst !== 32'h00000013 || if_rvc !== 1'b0) begin fails++; $display("FAIL flush_inst: got %h/%b expected 00000013/0", if_inst, if_rvc); end
        tests++; if (if_busy !== 1'b0 || ICACHE_ren !== 1'b0) begin fails++; $display("FAIL flush_idle: got busy=%b ren=%b expected 0/0", if_busy, ICACHE_ren); end
        tests++; if (accesses - a0 !== 1) begin fails++; $display("FAIL flush_access: got %0d expected 1", accesses - a0); end
    endtask

    task automatic test_flush_idle();
        int a0;
        a0 = accesses;
        @(posedge clk);
        #2;
        if_pc    = 32'h00000100;
        if_req   = 1'b1;
        if_flush = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (if_busy !== 1'b0) begin fails++; $display("FAIL flush_wins_busy: got %b expected 0", if_busy); end
        #1;
        if_req   = 1'b0;
        if_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (accesses - a0 !== 0) begin fails++; $display("FAIL flush_wins_access: got %0d expected 0", accesses - a0); end
    endtask

    task automatic test_reset_mid_fetch();
        @(posedge clk);
        #2;
        stall_left = 5;
        if_pc  = 32'h00000300;
        if_req = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (ICACHE_ren !== 1'b1) begin fails++; $display("FAIL rst_mid_started: got %b expected 1", ICACHE_ren); end
        @(posedge clk);
        #2;
        proc_reset = 1'b1;
        if_req     = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (ICACHE_ren !== 1'b0 || if_busy !== 1'b0 || ICACHE_addr !== 30'h0) begin fails++; $display("FAIL rst_mid_state: got ren=%b busy=%b addr=%h expected 0/0/0", ICACHE_ren, if_busy, ICACHE_addr); end
        #1;
        proc_reset   = 1'b0;
        stall_left   = 0;
        tb_tag_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [6];
        int lat, el;
        pcs = '{32'h100, 32'h104, 32'h106, 32'h10A, 32'h104, 32'h102};
        for (int i = 0; i < 6; i++) begin
            fetch(pcs[i], int'($urandom_range(0, 2)), lat, el);
            tests++; if (lat !== el) begin fails++; $display("FAIL b2b_lat[%0d]: got %0d expected %0d", i, lat, el); end
        end
    endtask

    initial begin
        proc_reset   = 1'b1;
        if_req       = 1'b0;
        if_pc        = '0;
        if_flush     = 1'b0;
        ICACHE_stall = 1'b0;
        ICACHE_rdata = '0;
        mem[30'h40]       = 32'h00A00093;
        mem[30'h41]       = 32'h12344505;
        mem[30'h42]       = 32'h00931111;
        mem[30'h43]       = 32'hFFFF00A0;
        mem[30'h3FFFFFFF] = 32'h1073ABCD;
        mem[30'h0]        = 32'h123400FF;
        mem[30'h80]       = 32'hCAFE0001;

        test_reset();
        test_aligned32();
        test_rvc();
        test_spill();
        test_stall_hit();
        test_flush_miss();
        test_flush_idle();
        test_reset_mid_fetch();
        test_back_to_back();

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_inst_q.size() != 0 || exp_addr_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d responses and %0d accesses outstanding, expected 0/0",
                     exp_inst_q.size(), exp_addr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rvc_fetch_aligner.md
Name: rvc_fetch_aligner

Overview:
- Sits between the pipeline fetch stage and the read-only instruction cache; is the cache's upstream requester.
- Turns halfword-aligned PC requests into complete raw instructions, either 16-bit RVC or 32-bit.
- Handles 32-bit instructions that straddle two cache words.
- Output feeds the decompression unit; compressed instructions are delivered zero-extended and flagged.

Parameters:
- ADDR_W, 30, word-address width toward the I-cache; PC width is ADDR_W+2.
- IDLE_INST, 32'h00000013, value held on if_inst after reset and after a flush.

Ports:
- clk  in  1  clock
- proc_reset  in  1  synchronous active-high reset
- if_req  in  1  core requests an instruction; held high with if_pc stable until if_valid
- if_pc  in  ADDR_W+2  instruction PC; bit0 ignored
- if_flush  in  1  redirect; abort the current request
- if_valid  out  1  one-cycle pulse: if_inst/if_rvc are valid
- if_inst  out  32  raw instruction; RVC delivered as {16'b0, half}
- if_rvc  out  1  instruction is compressed (low bits != 2'b11)
- if_busy  out  1  state != IDLE
- ICACHE_ren  out  1  cache read request
- ICACHE_addr  out  ADDR_W  word address
- ICACHE_stall  in  1  cache busy; data is valid in a cycle with ren=1 and stall=0
- ICACHE_rdata  in  32  cache word

Behaviour:
- Clock and reset: clk; proc_reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - if_valid=0, if_rvc=0, if_inst=IDLE_INST, if_busy=0.
  - ICACHE_ren=0, ICACHE_addr=0.
  - Word buffer invalid; pc_q=0; hi_q=0; flush_pend=0.
- FSM states: IDLE, F0, F1, RESP. All outputs are registered or decoded from state only.
- IDLE:
  - On if_req && !if_flush: pc_q<=if_pc, then go to F0.
- F0:
  - Drives ren=1, addr=pc_q[ADDR_W+1:2].
  - Waits while stall=1. On stall=0, capture word w and load the word buffer (tag=addr, data=w, valid=1).
  - pc_q[1]=0: if w[1:0]!=2'b11, inst={16'b0,w[15:0]}, rvc=1; else inst=w, rvc=0. Go to RESP.
  - pc_q[1]=1 and w[17:16]!=2'b11: inst={16'b0,w[31:16]}, rvc=1. Go to RESP.
  - pc_q[1]=1 and w[17:16]==2'b11: hi_q<=w[31:16]. Go to F1.
- F1:
  - Drives ren=1, addr=pc_q word+1, modulo 2^ADDR_W (wraps to 0).
  - On stall=0: inst={w[15:0],hi_q}, rvc=0; update the word buffer with this word. Go to RESP.
- RESP:
  - if_valid=1 for exactly one cycle with if_inst/if_rvc, then IDLE.
  - if_inst holds its value until the next RESP, flush or reset.
- Latency (cache hit, no spill): if_req sampled at cycle N, ren at N+1, if_valid at N+2. Spill adds 1 cycle plus any stall cycles.
- ICACHE_ren is 0 in IDLE and RESP; ICACHE_addr holds its last value.
- Flush:
  - In IDLE/RESP: next state IDLE, no if_valid, if_inst<=IDLE_INST.
  - In F0/F1 with stall=0: go to IDLE immediately; fetched data is discarded but the word buffer is still updated.
  - In F0/F1 with stall=1: set flush_pend. Keep ren/addr stable until stall=0 (the cache miss must complete), discard the data, go to IDLE.
  - if_valid is never asserted for a flushed request.
  - if_flush and if_req together in IDLE: the flush wins, no request is taken.
- Reset mid-fetch: immediate return to reset values and ren drops. The cache is reset by the same signal.
- if_req deasserted mid-request is illegal; behaviour is unspecified.

Optional Feature:
- Macro: WORD_REUSE_EN.
- When defined:
  - In IDLE, on a request whose word address matches the valid buffer tag, F0 is skipped. The buffered word is decoded with the F0 rules in the same cycle, going to RESP or F1.
  - Hit latency becomes 1 cycle: if_req at N, if_valid at N+1.
  - A spill uses the buffer for the low word only; F1 always accesses the cache.
  - Flush does not invalidate the buffer (instruction memory is read-only); reset does.
- When not defined: the buffer is write-only and unused; every request goes through F0.

Test Plan:
- Aligned 32-bit: pc=0x00000100, word 0x00A00093 -> ICACHE_addr=0x40; if_valid two cycles after req; if_inst=0x00A00093; if_rvc=0.
- Aligned RVC: pc=0x104, word 0x12344505 -> if_inst=0x00004505, if_rvc=1, single cache access.
- Upper RVC: pc=0x106, same word -> if_inst=0x00001234, if_rvc=1.
- Spill: pc=0x10A, word@0x42=0x0093xxxx, word@0x43=0xFFFF00A0 -> addresses 0x42 then 0x43; if_inst=0x00A00093; rvc=0. Repeat with pc at the last word (0xFFFFFFFE) -> second address wraps to 0.
- Flush during miss: req pc=0x200, stall held 10 cycles, flush on cycle 3 -> ren stays high until stall=0, no if_valid, if_inst=0x00000013, then IDLE.
- WORD_REUSE_EN: pc=0x104 then pc=0x106 -> second request makes no cache access and if_valid comes 1 cycle after req; without the macro, two cache accesses.
